// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the RISC-V core front end.
// Holds the PC generator state encoding and sequential increments.
package riscv_core_pkg;

    typedef enum logic [1:0] {
        PC_GEN_BOOT  = 2'd0,
        PC_GEN_RUN   = 2'd1,
        PC_GEN_FLUSH = 2'd2
    } pc_gen_state_e;

    localparam int unsigned PC_INC_RVI = 4;
    localparam int unsigned PC_INC_RVC = 2;

endpackage

// File: rtl/riscv_core_pc_gen_nextpc.sv
// Next-PC selection: trap > jump > branch priority, alignment check,
// and the sequential increment for a completed fetch.
module riscv_core_pc_gen_nextpc
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] pc,
    input  logic            fetch_done,
    input  logic            compressed,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            redirect,
    output logic            misaligned,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] seq_pc
);

    logic [XLEN-1:0] inc;

    // Trap vectors are trusted; only jump/branch targets are checked.
    always_comb begin
        redirect   = 1'b0;
        misaligned = 1'b0;
        target     = pc;
        if (trap) begin
            redirect = 1'b1;
            target   = trap_vector;
        end else if (jump) begin
            target     = jump_target;
            redirect   = ~jump_target[0];
            misaligned = jump_target[0];
        end else if (br_taken) begin
            target     = br_target;
            redirect   = ~br_target[0];
            misaligned = br_target[0];
        end
    end

    assign inc    = compressed ? XLEN'(PC_INC_RVC) : XLEN'(PC_INC_RVI);
    assign seq_pc = fetch_done ? pc + inc : pc;

endmodule

// File: rtl/riscv_core_pc_gen.sv
// Program counter generator: boot/run/flush FSM and PC registers.
// Redirects land on the PC one cycle after they are sampled.
module riscv_core_pc_gen
    import riscv_core_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0000_0000_8000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_pc_gen_br_taken,
    input  logic [XLEN-1:0] i_pc_gen_br_target,
    input  logic            i_pc_gen_jump,
    input  logic [XLEN-1:0] i_pc_gen_jump_target,
    input  logic            i_pc_gen_trap,
    input  logic [XLEN-1:0] i_pc_gen_trap_vector,
    input  logic            i_pc_gen_compressed,
    input  logic            i_pc_gen_stall,
    input  logic            i_pc_gen_fetch_ready,
    output logic [XLEN-1:0] o_pc_gen_pc,
    output logic            o_pc_gen_valid,
    output logic            o_pc_gen_flush,
    output logic            o_pc_gen_misaligned,
    output logic [XLEN-1:0] o_pc_gen_bad_addr
);

    pc_gen_state_e   state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] bad_addr, bad_addr_nxt;
    logic            flush, flush_nxt;
    logic            mis, mis_nxt;
    logic            valid;
    logic            fetch_done;
    logic            redirect, misaligned;
    logic [XLEN-1:0] target, seq_pc;

    assign fetch_done = valid & i_pc_gen_fetch_ready & ~i_pc_gen_stall;

    riscv_core_pc_gen_nextpc #(
        .XLEN(XLEN)
    ) u_nextpc (
        .pc          (pc),
        .fetch_done  (fetch_done),
        .compressed  (i_pc_gen_compressed),
        .trap        (i_pc_gen_trap),
        .trap_vector (i_pc_gen_trap_vector),
        .jump        (i_pc_gen_jump),
        .jump_target (i_pc_gen_jump_target),
        .br_taken    (i_pc_gen_br_taken),
        .br_target   (i_pc_gen_br_target),
        .redirect    (redirect),
        .misaligned  (misaligned),
        .target      (target),
        .seq_pc      (seq_pc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= PC_GEN_BOOT;
            pc       <= RESET_VECTOR;
            flush    <= 1'b0;
            mis      <= 1'b0;
            bad_addr <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            flush    <= flush_nxt;
            mis      <= mis_nxt;
            bad_addr <= bad_addr_nxt;
        end
    end

    // BOOT ignores every request; RUN and FLUSH share redirect handling.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        flush_nxt    = 1'b0;
        mis_nxt      = 1'b0;
        bad_addr_nxt = bad_addr;
        valid        = 1'b0;
        unique case (state)
            PC_GEN_BOOT: begin
                state_nxt = PC_GEN_RUN;
            end
            PC_GEN_RUN, PC_GEN_FLUSH: begin
                valid     = (state == PC_GEN_RUN);
                state_nxt = PC_GEN_RUN;
                if (redirect) begin
                    pc_nxt    = target;
                    flush_nxt = 1'b1;
                    state_nxt = PC_GEN_FLUSH;
                end else if (misaligned) begin
                    mis_nxt      = 1'b1;
                    bad_addr_nxt = target;
                end else begin
                    pc_nxt = seq_pc;
                end
            end
            default: begin
                state_nxt = PC_GEN_BOOT;
            end
        endcase
    end

    assign o_pc_gen_pc         = pc;
    assign o_pc_gen_valid      = valid;
    assign o_pc_gen_flush      = flush;
    assign o_pc_gen_misaligned = mis;
    assign o_pc_gen_bad_addr   = bad_addr;

endmodule

// File: tb/tb_riscv_core_pc_gen.sv
// Self-checking bench for riscv_core_pc_gen: directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_riscv_core_pc_gen;

    localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;
    logic        jump = 1'b0;
    logic [63:0] jump_target = '0;
    logic        trap = 1'b0;
    logic [63:0] trap_vector = '0;
    logic        compressed = 1'b0;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic [63:0] pc;
    logic        valid;
    logic        flush;
    logic        misaligned;
    logic [63:0] bad_addr;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: expected visible outputs after each edge.
    bit          m_boot;
    bit          m_flushing;
    logic [63:0] m_pc;
    bit          m_flush;
    bit          m_mis;
    logic [63:0] m_bad;

    riscv_core_pc_gen dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_pc_gen_br_taken    (br_taken),
        .i_pc_gen_br_target   (br_target),
        .i_pc_gen_jump        (jump),
        .i_pc_gen_jump_target (jump_target),
        .i_pc_gen_trap        (trap),
        .i_pc_gen_trap_vector (trap_vector),
        .i_pc_gen_compressed  (compressed),
        .i_pc_gen_stall       (stall),
        .i_pc_gen_fetch_ready (fetch_ready),
        .o_pc_gen_pc          (pc),
        .o_pc_gen_valid       (valid),
        .o_pc_gen_flush       (flush),
        .o_pc_gen_misaligned  (misaligned),
        .o_pc_gen_bad_addr    (bad_addr)
    );

    always #5 clk = ~clk;

    function automatic bit m_valid();
        return !m_boot && !m_flushing;
    endfunction

    task automatic m_reset();
        m_boot     = 1'b1;
        m_flushing = 1'b0;
        m_pc       = RV;
        m_flush    = 1'b0;
        m_mis      = 1'b0;
        m_bad      = '0;
    endtask

    task automatic m_step();
        bit          fired;
        bit          src;
        logic [63:0] tgt;
        fired = m_valid() && fetch_ready && !stall;
        src   = trap || jump || br_taken;
        tgt   = trap ? trap_vector : (jump ? jump_target : br_target);
        m_flush = 1'b0;
        m_mis   = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (src && (trap || tgt[0] == 1'b0)) begin
            m_pc       = tgt;
            m_flush    = 1'b1;
            m_flushing = 1'b1;
        end else if (src) begin
            m_mis      = 1'b1;
            m_bad      = tgt;
            m_flushing = 1'b0;
        end else begin
            if (fired) m_pc = m_pc + (compressed ? 64'd2 : 64'd4);
            m_flushing = 1'b0;
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        br_taken = 1'b0;
        jump     = 1'b0;
        trap     = 1'b0;
    endtask

    task automatic test_reset();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors += 5;
        if (pc !== RV) begin
            miscompares++;
            $display("FAIL reset_pc got=%h exp=%h", pc, RV);
        end
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got=%b exp=0", valid);
        end
        if (flush !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flush got=%b exp=0", flush);
        end
        if (misaligned !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mis got=%b exp=0", misaligned);
        end
        if (bad_addr !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_bad got=%h exp=0", bad_addr);
        end
    endtask

    task automatic test_sequential();
        logic [63:0] exp_seq [4];
        bit          cpat [3];
        exp_seq = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0006, 64'h8000_000A};
        cpat    = '{1'b0, 1'b1, 1'b0};
        rst_n = 1'b1;
        fetch_ready = 1'b1;
        #1;
        vectors++;
        if (valid !== 1'b0 || pc !== RV) begin
            miscompares++;
            $display("FAIL boot got valid=%b pc=%h exp valid=0 pc=%h", valid, pc, RV);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (pc !== exp_seq[i] || valid !== 1'b1) begin
                miscompares++;
                $display("FAIL seq%0d got pc=%h valid=%b exp pc=%h valid=1", i, pc, valid, exp_seq[i]);
            end
            if (i < 3) begin
                compressed = cpat[i];
                tick();
            end
        end
        compressed = 1'b0;
    endtask

    task automatic test_branch_stall();
        br_taken  = 1'b1;
        br_target = 64'h8000_0100;
        stall     = 1'b1;
        tick();
        clear_req();
        stall = 1'b0;
        vectors++;
        if (pc !== 64'h8000_0100 || flush !== 1'b1 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL br_stall got pc=%h flush=%b valid=%b exp pc=80000100 flush=1 valid=0", pc, flush, valid);
        end
        tick();
        vectors++;
        if (valid !== 1'b1 || flush !== 1'b0 || pc !== 64'h8000_0100) begin
            miscompares++;
            $display("FAIL br_after got pc=%h flush=%b valid=%b exp pc=80000100 flush=0 valid=1", pc, flush, valid);
        end
    endtask

    task automatic test_priority();
        trap        = 1'b1;
        trap_vector = 64'h100;
        jump        = 1'b1;
        jump_target = 64'h8000_0200;
        br_taken    = 1'b1;
        br_target   = 64'h8000_0300;
        tick();
        clear_req();
        vectors++;
        if (pc !== 64'h100 || flush !== 1'b1) begin
            miscompares++;
            $display("FAIL prio got pc=%h flush=%b exp pc=100 flush=1", pc, flush);
        end
        tick();
        vectors++;
        if (flush !== 1'b0 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_pulse got flush=%b valid=%b exp flush=0 valid=1", flush, valid);
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] held;
        held        = pc;
        jump        = 1'b1;
        jump_target = 64'h8000_0201;
        tick();
        clear_req();
        vectors++;
        if (misaligned !== 1'b1 || bad_addr !== 64'h8000_0201 || pc !== held || flush !== 1'b0) begin
            miscompares++;
            $display("FAIL mis got mis=%b bad=%h pc=%h flush=%b exp mis=1 bad=80000201 pc=%h flush=0",
                     misaligned, bad_addr, pc, flush, held);
        end
        stall = 1'b1;
        tick();
        stall = 1'b0;
        vectors++;
        if (misaligned !== 1'b0 || bad_addr !== 64'h8000_0201) begin
            miscompares++;
            $display("FAIL mis_pulse got mis=%b bad=%h exp mis=0 bad=80000201", misaligned, bad_addr);
        end
    endtask

    task automatic test_back_to_back();
        br_taken  = 1'b1;
        br_target = 64'h8000_0400;
        tick();
        clear_req();
        jump        = 1'b1;
        jump_target = 64'h8000_0800;
        tick();
        clear_req();
        vectors++;
        if (pc !== 64'h8000_0800 || flush !== 1'b1 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b got pc=%h flush=%b valid=%b exp pc=80000800 flush=1 valid=0", pc, flush, valid);
        end
        tick();
        vectors++;
        if (valid !== 1'b1 || flush !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_run got valid=%b flush=%b exp valid=1 flush=0", valid, flush);
        end
    endtask

    task automatic test_wrap();
        br_taken  = 1'b1;
        br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        clear_req();
        tick();
        compressed  = 1'b0;
        fetch_ready = 1'b1;
        tick();
        vectors++;
        if (pc !== 64'h0 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap got pc=%h valid=%b exp pc=0 valid=1", pc, valid);
        end
    endtask

    task automatic test_reset_mid();
        br_taken  = 1'b1;
        br_target = 64'h8000_0A00;
        tick();
        clear_req();
        rst_n = 1'b0;
        #1;
        m_reset();
        vectors++;
        if (flush !== 1'b0 || pc !== RV || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid got flush=%b pc=%h valid=%b exp flush=0 pc=%h valid=0", flush, pc, valid, RV);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (valid !== 1'b0 || pc !== RV) begin
            miscompares++;
            $display("FAIL rst_boot got valid=%b pc=%h exp valid=0 pc=%h", valid, pc, RV);
        end
        tick();
        vectors++;
        if (valid !== 1'b1 || pc !== RV) begin
            miscompares++;
            $display("FAIL rst_run got valid=%b pc=%h exp valid=1 pc=%h", valid, pc, RV);
        end
    endtask

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        t[0] = ($urandom_range(3) == 0);
        return t;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            trap        = ($urandom_range(19) == 0);
            jump        = ($urandom_range(11) == 0);
            br_taken    = ($urandom_range(9) == 0);
            trap_vector = rand_target();
            jump_target = rand_target();
            br_target   = rand_target();
            compressed  = $urandom_range(1) == 1;
            stall       = ($urandom_range(3) == 0);
            fetch_ready = ($urandom_range(3) != 0);
            tick();
            vectors++;
            if (pc !== m_pc || valid !== m_valid() || flush !== m_flush ||
                misaligned !== m_mis || bad_addr !== m_bad) begin
                miscompares++;
                $display("FAIL rnd%0d got pc=%h v=%b f=%b m=%b bad=%h exp pc=%h v=%b f=%b m=%b bad=%h",
                         i, pc, valid, flush, misaligned, bad_addr,
                         m_pc, m_valid(), m_flush, m_mis, m_bad);
            end
        end
        clear_req();
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_stall();
        test_priority();
        test_misaligned();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/riscv_core_pc_gen.md
RISCV_CORE_PC_GEN -- requirements
Module: riscv_core_pc_gen

Interface
REQ-001 Parameter XLEN, default 64: width of all address ports.
REQ-002 Parameter RESET_VECTOR, default 64'h0000_0000_8000_0000: first fetch address after reset.
REQ-003 i_clk  input  1  core clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_pc_gen_br_taken  input  1  branch resolved taken (from branch unit).
REQ-006 i_pc_gen_br_target  input  XLEN  branch target address.
REQ-007 i_pc_gen_jump  input  1  JAL/JALR resolved.
REQ-008 i_pc_gen_jump_target  input  XLEN  jump target address.
REQ-009 i_pc_gen_trap  input  1  trap/exception redirect request.
REQ-010 i_pc_gen_trap_vector  input  XLEN  trap handler address.
REQ-011 i_pc_gen_compressed  input  1  instruction at o_pc_gen_pc is 16-bit.
REQ-012 i_pc_gen_stall  input  1  hazard-unit stall; freezes PC.
REQ-013 i_pc_gen_fetch_ready  input  1  fetch accepts the current PC.
REQ-014 o_pc_gen_pc  output  XLEN  current fetch address.
REQ-015 o_pc_gen_valid  output  1  o_pc_gen_pc is a valid fetch request.
REQ-016 o_pc_gen_flush  output  1  one-cycle pulse: kill younger IF/ID instructions.
REQ-017 o_pc_gen_misaligned  output  1  one-cycle pulse: redirect target had bit 0 set.
REQ-018 o_pc_gen_bad_addr  output  XLEN  faulting target, registered with the misaligned pulse.

Function
REQ-019 FSM states SHALL be BOOT, RUN, FLUSH.
REQ-020 BOOT: valid=0, PC=RESET_VECTOR; next cycle unconditionally RUN.
REQ-021 RUN: valid=1; a fetch SHALL complete when valid & fetch_ready & ~stall.
REQ-022 On a completed fetch with no redirect, PC SHALL advance by 2 if compressed, else by 4, modulo 2^XLEN (wrap, no flag).
REQ-023 With no completed fetch and no redirect, PC SHALL hold.
REQ-024 Redirect priority SHALL be trap > jump > branch; only the highest active source is used.
REQ-025 Trap: PC <= trap_vector, flush=1 next cycle, state FLUSH; trap is accepted regardless of stall or fetch_ready.
REQ-026 Jump/branch with target[0]=0: PC <= target, flush=1 next cycle, state FLUSH; accepted regardless of stall.
REQ-027 Jump/branch with target[0]=1: PC SHALL hold; misaligned=1 and bad_addr=target next cycle; no flush; state unchanged.
REQ-028 FLUSH: valid=0 for exactly one cycle; then RUN.
REQ-029 A redirect arriving in FLUSH SHALL be applied as in RUN and keep the FSM in FLUSH for one more cycle.
REQ-030 A redirect arriving in BOOT SHALL be ignored.
REQ-031 flush and misaligned SHALL each be high for one cycle per event; bad_addr SHALL hold its value until the next misaligned event.
REQ-032 Redirect latency: the target SHALL appear on o_pc_gen_pc on the cycle after the request is sampled.

Reset
REQ-033 While i_rst_n=0, outputs SHALL be: pc=RESET_VECTOR, valid=0, flush=0, misaligned=0, bad_addr=0, state=BOOT.
REQ-034 Reset asserted mid-operation SHALL abort any pending flush or misaligned pulse immediately.

Structure
REQ-035 The shared package riscv_core_pkg SHALL hold the state enum pc_gen_state_e and the constants PC_INC_RVI=4 and PC_INC_RVC=2.
REQ-036 The combinational priority mux with the target[0] check SHALL be a sub-module, riscv_core_pc_gen_nextpc; the FSM and registers SHALL stay in the top.

Verification
REQ-037 Reset release, fetch_ready=1, compressed pattern 0,1,0 -> BOOT for one cycle (valid=0); PC sequence 0x8000_0000, 0x8000_0004, 0x8000_0006, 0x8000_000A.
REQ-038 Branch taken with target 0x8000_0100, stall=1 -> next cycle pc=0x8000_0100, flush=1, valid=0; the following cycle valid=1.
REQ-039 Trap (vector 0x100), jump, and branch all asserted in the same cycle -> pc=0x100; exactly one flush pulse.
REQ-040 Jump with target 0x8000_0201 -> misaligned=1 for one cycle, bad_addr=0x8000_0201, PC unchanged, flush=0.
REQ-041 PC=0xFFFF_FFFF_FFFF_FFFC, fetch completes as non-compressed -> pc=0x0.
REQ-042 Reset asserted the cycle after a branch redirect -> flush=0 and pc=RESET_VECTOR immediately; BOOT follows release.
